clock_button_ctrl: RTL and testbench

//  Input side of the clock's seven-segment display path. Debounces the raw push-buttons
//  and runs the view/adjust FSM. Drives smh_dmy, dem_chinh and blink_led into Display,
//  and sends one-cycle inc/dec pulses to the time/date counters.

---
 rtl/clock_button_ctrl_pkg.sv | 41 ++++
 rtl/clock_button_ctrl_if.sv | 31 +++
 rtl/clock_button_ctrl_key_debounce.sv | 67 ++++++
 rtl/clock_button_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_clock_button_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_button_ctrl_pkg.sv
// Shared definitions for the clock user-interface path: field codes used by
// Display and the time/date counters, FSM state encoding, key indices and a
// counter-width helper.
package clock_ui_pkg;

   // Selected field code, shared with Display and the counters
   typedef logic [1:0] field_t;

   localparam field_t FIELD_LO  = 2'b00;   // ss / yyyy
   localparam field_t FIELD_MID = 2'b01;   // mm / mo
   localparam field_t FIELD_HI  = 2'b10;   // hh / dd

   // View/adjust FSM states
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ADJUST = 1'b1
   } ui_state_t;

   // Key positions inside the packed key vectors of the top level
   localparam int NUM_KEYS = 5;
   localparam int KEY_VIEW = 0;
   localparam int KEY_ADJ  = 1;
   localparam int KEY_SEL  = 2;
   localparam int KEY_UP   = 3;
   localparam int KEY_DN   = 4;

   // Field rotation LO -> MID -> HI -> LO; the unused code 11 also falls back to LO
   function automatic field_t next_field(input field_t f);
      case (f)
         FIELD_LO:  next_field = FIELD_MID;
         FIELD_MID: next_field = FIELD_HI;
         default:   next_field = FIELD_LO;
      endcase
   endfunction

   // Bits needed to hold 0..n-1, never less than one bit
   function automatic int cnt_width(input int n);
      cnt_width = (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_button_ctrl_if.sv
// Key and display-control bundle of the clock button controller.
// master: the side that owns the keys and consumes the display controls.
// slave:  the button controller itself.
interface clock_button_ctrl_if;
   import clock_ui_pkg::*;

   // Raw active-low push-buttons
   logic   btn_view_n;
   logic   btn_adj_n;
   logic   btn_sel_n;
   logic   btn_up_n;
   logic   btn_dn_n;

   // Display controls and counter strobes
   logic   smh_dmy;
   logic   dem_chinh;
   field_t blink_led;
   logic   inc_pulse;
   logic   dec_pulse;

   modport master (
      output btn_view_n, btn_adj_n, btn_sel_n, btn_up_n, btn_dn_n,
      input  smh_dmy, dem_chinh, blink_led, inc_pulse, dec_pulse
   );

   modport slave (
      input  btn_view_n, btn_adj_n, btn_sel_n, btn_up_n, btn_dn_n,
      output smh_dmy, dem_chinh, blink_led, inc_pulse, dec_pulse
   );

endinterface

// File: rtl/clock_button_ctrl_key_debounce.sv
// key_debounce: one raw active-low key -> 2-FF synchronizer -> stability
// counter -> debounced level plus a registered one-cycle press event.
// o_level keeps the key polarity (1 = released, 0 = pressed).
module key_debounce
   import clock_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // Bring the asynchronous key into the clock domain; idle level is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b1;
      end else if (r_sync2 == r_level) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt   <= '0;
         r_level <= r_sync2;
      end else begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // Press event: debounced level went 1 -> 0 on the previous edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level_d <= 1'b1;
         r_press   <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_press   <= r_level_d & ~r_level;
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/clock_button_ctrl.sv
// clock_button_ctrl: debounces the five clock keys and runs the view/adjust
// FSM that drives the Display controls and the inc/dec strobes towards the
// time/date counters. Up/down keys auto-repeat while held in adjust mode and
// adjust mode exits by itself after a period with no key press.
module clock_button_ctrl
   import clock_ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 10_000_000,
   parameter int TIMEOUT_CYCLES  = 500_000_000
) (
   input logic                clk,
   input logic                rst_n,
   clock_button_ctrl_if.slave bus
);

   // The repeat counter serves both the initial delay and the repeat period
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W   = cnt_width(RP_MAX);
   localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);

   localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE - 1);
   localparam logic [RP_W-1:0] RP_ONE        = RP_W'(1);
   localparam logic [TO_W-1:0] TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE        = TO_W'(1);

   // ---------------------------------------------------------------- keys
   logic [NUM_KEYS-1:0] w_key_raw_n;
   logic [NUM_KEYS-1:0] w_level_n;
   logic [NUM_KEYS-1:0] w_press;
   logic                w_unused_levels;

   assign w_key_raw_n = {bus.btn_dn_n, bus.btn_up_n, bus.btn_sel_n,
                         bus.btn_adj_n, bus.btn_view_n};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_key_n (w_key_raw_n[gi]),
            .o_level (w_level_n[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   // view/adj/sel act on press events only; their held levels are not needed
   assign w_unused_levels = &{1'b0, w_level_n[KEY_SEL:KEY_VIEW]};

   // ---------------------------------------------------------- state regs
   ui_state_t       r_state;
   ui_state_t       w_state_next;
   logic            r_smh_dmy;
   logic            w_smh_dmy_next;
   field_t          r_blink_led;
   field_t          w_blink_led_next;
   logic            r_inc_pulse;
   logic            w_inc_pulse_next;
   logic            r_dec_pulse;
   logic            w_dec_pulse_next;
   logic [RP_W-1:0] r_rep_cnt;
   logic [RP_W-1:0] w_rep_cnt_next;
   logic            r_rep_phase;      // 0: waiting initial delay, 1: repeating
   logic            w_rep_phase_next;
   logic [TO_W-1:0] r_to_cnt;
   logic [TO_W-1:0] w_to_cnt_next;

   logic            w_up_held;
   logic            w_dn_held;
   logic            w_one_held;       // exactly one of up/dn is held
   logic            w_updn_press;
   logic            w_any_press;
   logic            w_rep_tick;
   logic            w_timeout;
   logic            w_leave_adj;

   assign w_up_held    = ~w_level_n[KEY_UP];
   assign w_dn_held    = ~w_level_n[KEY_DN];
   assign w_one_held   = w_up_held ^ w_dn_held;
   assign w_updn_press = w_press[KEY_UP] | w_press[KEY_DN];
   assign w_any_press  = |w_press;

   // Repeat and timeout counters; both only run in ADJUST
   always_comb begin
      w_rep_cnt_next   = r_rep_cnt;
      w_rep_phase_next = r_rep_phase;
      w_rep_tick       = 1'b0;
      w_to_cnt_next    = r_to_cnt;
      w_timeout        = 1'b0;
      w_leave_adj      = 1'b0;

      if (r_state != ST_ADJUST) begin
         w_rep_cnt_next   = '0;
         w_rep_phase_next = 1'b0;
         w_to_cnt_next    = '0;
      end else begin
         // A fresh up/dn press restarts the delay; both or neither held stops it
         if (!w_one_held || w_updn_press) begin
            w_rep_cnt_next   = '0;
            w_rep_phase_next = 1'b0;
         end else if ((!r_rep_phase && (r_rep_cnt == RP_DELAY_LAST)) ||
                      ( r_rep_phase && (r_rep_cnt == RP_RATE_LAST))) begin
            w_rep_tick       = 1'b1;
            w_rep_cnt_next   = '0;
            w_rep_phase_next = 1'b1;
         end else begin
            w_rep_cnt_next = r_rep_cnt + RP_ONE;
         end

         if (w_any_press) begin
            w_to_cnt_next = '0;
         end else if (r_to_cnt == TO_LAST) begin
            w_timeout     = 1'b1;
            w_to_cnt_next = '0;
         end else begin
            w_to_cnt_next = r_to_cnt + TO_ONE;
         end

         // Any exit from ADJUST starts the next visit with clean counters
         w_leave_adj = w_press[KEY_ADJ] | w_timeout;
         if (w_leave_adj) begin
            w_rep_cnt_next   = '0;
            w_rep_phase_next = 1'b0;
            w_to_cnt_next    = '0;
         end
      end
   end

   // FSM next state and registered outputs; adj > view > sel > up/dn
   always_comb begin
      w_state_next     = r_state;
      w_smh_dmy_next   = r_smh_dmy;
      w_blink_led_next = r_blink_led;
      w_inc_pulse_next = 1'b0;
      w_dec_pulse_next = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_press[KEY_ADJ]) begin
               w_state_next     = ST_ADJUST;
               w_blink_led_next = FIELD_LO;
            end else if (w_press[KEY_VIEW]) begin
               w_smh_dmy_next = ~r_smh_dmy;
            end
         end
         ST_ADJUST: begin
            if (w_leave_adj) begin
               w_state_next     = ST_IDLE;
               w_blink_led_next = FIELD_LO;
            end else if (w_press[KEY_VIEW]) begin
               w_smh_dmy_next   = ~r_smh_dmy;
               w_blink_led_next = FIELD_LO;
            end else if (w_press[KEY_SEL]) begin
               w_blink_led_next = next_field(r_blink_led);
            end else if ((w_updn_press || w_rep_tick) && w_one_held) begin
               // A pressed key is already debounced-held, so the held
               // level tells which strobe to send; both held sends none
               w_inc_pulse_next = w_up_held;
               w_dec_pulse_next = w_dn_held;
            end
         end
         default: begin
            w_state_next     = ST_IDLE;
            w_blink_led_next = FIELD_LO;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_smh_dmy   <= 1'b0;
         r_blink_led <= FIELD_LO;
         r_inc_pulse <= 1'b0;
         r_dec_pulse <= 1'b0;
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
         r_to_cnt    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_smh_dmy   <= w_smh_dmy_next;
         r_blink_led <= w_blink_led_next;
         r_inc_pulse <= w_inc_pulse_next;
         r_dec_pulse <= w_dec_pulse_next;
         r_rep_cnt   <= w_rep_cnt_next;
         r_rep_phase <= w_rep_phase_next;
         r_to_cnt    <= w_to_cnt_next;
      end
   end

   assign bus.smh_dmy   = r_smh_dmy;
   assign bus.dem_chinh = (r_state == ST_ADJUST);
   assign bus.blink_led = r_blink_led;
   assign bus.inc_pulse = r_inc_pulse;
   assign bus.dec_pulse = r_dec_pulse;

endmodule

// File: tb/tb_clock_button_ctrl.sv
// Scoreboard bench for clock_button_ctrl with short simulation parameters.
// Stimulus pushes every expected output change (cycle + value) into a queue;
// the monitor pops one entry for each change it sees on the outputs.
// Output vector layout: {smh_dmy, dem_chinh, blink_led[1:0], inc_pulse, dec_pulse}.
// A raw key edge driven just after edge t gives a press event during cycle t+7
// and the resulting output change is visible after edge t+8.
module tb_clock_button_ctrl;
   import clock_ui_pkg::*;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RR  = 8;
   localparam int TO  = 100;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   clock_button_ctrl_if bus ();

   clock_button_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   bit         mon_en = 1'b0;
   logic [5:0] prev_vec;

   int         q_cyc[$];
   logic [5:0] q_vec[$];
   string      q_name[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [5:0] cur_vec();
      return {bus.smh_dmy, bus.dem_chinh, bus.blink_led, bus.inc_pulse, bus.dec_pulse};
   endfunction

   function automatic logic [5:0] mk(input bit smh, input bit dem, input logic [1:0] bl,
                                     input bit inc, input bit dec);
      return {smh, dem, bl, inc, dec};
   endfunction

   function automatic void expect_at(input int c, input logic [5:0] v, input string nm);
      q_cyc.push_back(c);
      q_vec.push_back(v);
      q_name.push_back(nm);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         KEY_VIEW: bus.btn_view_n = v;
         KEY_ADJ:  bus.btn_adj_n  = v;
         KEY_SEL:  bus.btn_sel_n  = v;
         KEY_UP:   bus.btn_up_n   = v;
         default:  bus.btn_dn_n   = v;
      endcase
   endtask

   task automatic press(input int k, input int hold, input int gap);
      set_key(k, 1'b0);
      step(hold);
      set_key(k, 1'b1);
      step(gap);
   endtask

   task automatic check_now(input string nm, input logic [5:0] req);
      logic [5:0] v;
      v = cur_vec();
      n_checks++;
      if (v === req) begin
         n_pass++;
         $display("ok %s cyc=%0d vec=%b", nm, cyc, v);
      end else begin
         $display("FAIL %s got=%b required=%b", nm, v, req);
      end
   endtask

   // Monitor: every change of the output vector must match the next queued entry
   always @(negedge clk) begin : monitor
      logic [5:0] v;
      logic [5:0] ev;
      int         ec;
      string      en;
      if (mon_en) begin
         v = cur_vec();
         if (v !== prev_vec) begin
            n_checks++;
            if (q_vec.size() == 0) begin
               $display("FAIL unexpected_change cyc=%0d got=%b required=no_change", cyc, v);
            end else begin
               ec = q_cyc.pop_front();
               ev = q_vec.pop_front();
               en = q_name.pop_front();
               if (v === ev && cyc == ec) begin
                  n_pass++;
                  $display("ok %s cyc=%0d vec=%b", en, cyc, v);
               end else begin
                  $display("FAIL %s got=%b@%0d required=%b@%0d", en, v, cyc, ev, ec);
               end
            end
            prev_vec = v;
         end
      end
   end

   initial begin : stim
      int t;
      int p;
      bus.btn_view_n = 1'b1;
      bus.btn_adj_n  = 1'b1;
      bus.btn_sel_n  = 1'b1;
      bus.btn_up_n   = 1'b1;
      bus.btn_dn_n   = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(2);
      check_now("reset_outputs", 6'b000000);
      prev_vec = cur_vec();
      mon_en   = 1'b1;

      // 3-cycle glitch on adj is shorter than DEB and must be ignored
      press(KEY_ADJ, 3, 15);
      check_now("glitch_ignored", 6'b000000);

      // adj held: ADJUST visible 8 edges after the raw edge
      t = cyc;
      expect_at(t + 8, mk(0, 1, 2'b00, 0, 0), "adj_enter");
      press(KEY_ADJ, 10, 10);

      // three sel presses walk 00 -> 01 -> 10 -> 00
      t = cyc; expect_at(t + 8, mk(0, 1, 2'b01, 0, 0), "sel_1");
      press(KEY_SEL, 6, 10);
      t = cyc; expect_at(t + 8, mk(0, 1, 2'b10, 0, 0), "sel_2");
      press(KEY_SEL, 6, 10);
      t = cyc; expect_at(t + 8, mk(0, 1, 2'b00, 0, 0), "sel_3");
      press(KEY_SEL, 6, 10);

      // up held 50 cycles: press pulse at t+8; ticks at cycles t+27, t+35,
      // t+43, t+51 give pulses one edge later; debounced hold ends after t+55
      t = cyc;
      expect_at(t + 8,  mk(0, 1, 2'b00, 1, 0), "up_press");
      expect_at(t + 9,  mk(0, 1, 2'b00, 0, 0), "up_press_end");
      expect_at(t + 28, mk(0, 1, 2'b00, 1, 0), "up_rep1");
      expect_at(t + 29, mk(0, 1, 2'b00, 0, 0), "up_rep1_end");
      expect_at(t + 36, mk(0, 1, 2'b00, 1, 0), "up_rep2");
      expect_at(t + 37, mk(0, 1, 2'b00, 0, 0), "up_rep2_end");
      expect_at(t + 44, mk(0, 1, 2'b00, 1, 0), "up_rep3");
      expect_at(t + 45, mk(0, 1, 2'b00, 0, 0), "up_rep3_end");
      expect_at(t + 52, mk(0, 1, 2'b00, 1, 0), "up_rep4");
      expect_at(t + 53, mk(0, 1, 2'b00, 0, 0), "up_rep4_end");
      press(KEY_UP, 50, 12);

      // up and dn in the same cycle: no strobe at all
      set_key(KEY_UP, 1'b0);
      set_key(KEY_DN, 1'b0);
      step(6);
      set_key(KEY_UP, 1'b1);
      set_key(KEY_DN, 1'b1);
      step(12);

      // single dn press gives one dec strobe
      t = cyc;
      expect_at(t + 8, mk(0, 1, 2'b00, 0, 1), "dn_press");
      expect_at(t + 9, mk(0, 1, 2'b00, 0, 0), "dn_press_end");
      press(KEY_DN, 6, 10);

      // sel to 01, then view toggles smh_dmy and forces field 00
      t = cyc; expect_at(t + 8, mk(0, 1, 2'b01, 0, 0), "sel_mid");
      press(KEY_SEL, 6, 10);
      t = cyc; expect_at(t + 8, mk(1, 1, 2'b00, 0, 0), "view_adjust");
      p = t + 7;
      press(KEY_VIEW, 6, 10);

      // no key after the view event: timeout exits 101 edges after it
      expect_at(p + 101, mk(1, 0, 2'b00, 0, 0), "timeout_exit");
      step(100);

      // up in IDLE is ignored; view in IDLE toggles twice
      press(KEY_UP, 6, 10);
      t = cyc; expect_at(t + 8, mk(0, 0, 2'b00, 0, 0), "view_idle_0");
      press(KEY_VIEW, 6, 10);
      t = cyc; expect_at(t + 8, mk(1, 0, 2'b00, 0, 0), "view_idle_1");
      press(KEY_VIEW, 6, 10);

      // back to ADJUST, hold up, reset for 2 cycles while it is still held
      t = cyc; expect_at(t + 8, mk(1, 1, 2'b00, 0, 0), "adj_enter_2");
      press(KEY_ADJ, 6, 10);
      t = cyc;
      set_key(KEY_UP, 1'b0);
      expect_at(t + 8, mk(1, 1, 2'b00, 1, 0), "up_before_rst");
      expect_at(t + 9, mk(1, 1, 2'b00, 0, 0), "up_before_rst_end");
      step(12);
      expect_at(t + 12, 6'b000000, "reset_mid");
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(20);
      set_key(KEY_UP, 1'b1);
      step(15);
      check_now("idle_after_reset", 6'b000000);

      step(5);
      mon_en = 1'b0;
      while (q_vec.size() > 0) begin
         n_checks++;
         $display("FAIL missing_%s got=no_change required=%b@%0d",
                  q_name.pop_front(), q_vec.pop_front(), q_cyc.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
